// File: rtl/sp_ram_frame_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_buf_pkg
// Purpose  : Shared types and helpers for the SP RAM frame buffer controller.
//            - state_e    : controller phase (FILL = writing, DRAIN = reading)
//            - SKID_DEPTH : output skid FIFO depth
//            - SKID_CNT_W : width of the skid FIFO occupancy count
//            - ad_fmt()   : places a word address on the 14-bit SP AD bus
// Revision : 1.0 - initial release
// ============================================================================
package sp_buf_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // The SP AD bus addresses bits, not words; the word address sits at
    // addr_lsb and every other AD bit must stay zero.
    function automatic logic [13:0] ad_fmt(input logic [13:0] word_addr,
                                           input int unsigned addr_lsb);
        ad_fmt = word_addr << addr_lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_frame_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_frame_buffer_ctrl_if
// Purpose  : valid/ready sample stream.
//            data  : sample word            (master -> slave)
//            valid : data is valid          (master -> slave)
//            ready : slave accepts the word (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface sp_ram_frame_buffer_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/sp_ram_frame_buffer_ctrl_skid.sv
`default_nettype none
// ============================================================================
// Module   : sp_buf_skid
// Purpose  : SKID_DEPTH-entry FIFO of {last, data} in front of the output port.
//            i_push/i_push_data/i_push_last : write side (caller never overflows)
//            i_pop                          : consume head (only while o_valid)
//            o_valid/o_head_data/o_head_last: FIFO head
//            o_cnt                          : current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module sp_buf_skid
    import sp_buf_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   i_push,
    input  wire  [DATA_W-1:0]     i_push_data,
    input  wire                   i_push_last,
    input  wire                   i_pop,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_head_data,
    output logic                  o_head_last,
    output logic [SKID_CNT_W-1:0] o_cnt
);
    localparam int c_IDX_W = $clog2(SKID_DEPTH);

    logic [DATA_W:0]         mem_q [SKID_DEPTH];
    logic [DATA_W:0]         mem_d [SKID_DEPTH];
    logic [c_IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [c_IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [SKID_CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        if (i_push) begin
            mem_d[wr_idx_q] = {i_push_last, i_push_data};
            wr_idx_d        = wr_idx_q + c_IDX_W'(1);
        end
        if (i_pop) begin
            rd_idx_d = rd_idx_q + c_IDX_W'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({i_push, i_pop})
            2'b10:   cnt_d = cnt_q + SKID_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - SKID_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is qualified by cnt_q, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_valid                    = (cnt_q != '0);
    assign {o_head_last, o_head_data} = mem_q[rd_idx_q];
    assign o_cnt                      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sp_ram_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_frame_buffer_ctrl
// Purpose  : Frame buffer controller for one SP RAM. Fills FRAME_LEN words
//            from the input stream, then drains them in order to the output
//            stream with m_last on the final word. One RAM port, so fill and
//            drain alternate.
// Ports    : clk, rst_n (async, active low)
//            s          : input stream (slave)  - ready only while filling
//            m          : output stream (master) - skid FIFO head
//            m_last     : head is word FRAME_LEN-1
//            frame_done : pulse when the last word is accepted
//            ram_*      : SP RAM port (CE, OCE, WRE, RESET, AD, DI, DO)
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_frame_buffer_ctrl
    import sp_buf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 32,
    parameter int ADDR_W    = 5,
    parameter int ADDR_LSB  = 4,
    parameter int READ_LAT  = 1
) (
    input  wire                       clk,
    input  wire                       rst_n,
    sp_ram_frame_buffer_ctrl_if.slave  s,
    sp_ram_frame_buffer_ctrl_if.master m,
    output logic                      m_last,
    output logic                      frame_done,
    output logic                      ram_ce,
    output logic                      ram_oce,
    output logic                      ram_wre,
    output logic                      ram_reset,
    output logic [13:0]               ram_ad,
    output logic [DATA_W-1:0]         ram_di,
    input  wire  [DATA_W-1:0]         ram_do
);
    localparam int                c_CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LEN = c_CNT_W'(FRAME_LEN);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;   // index of next word pushed into the FIFO
    logic [c_CNT_W-1:0]  issued_q, issued_d;   // reads issued this frame
    logic                inflight_q, inflight_d;

    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_credit;
    logic [ADDR_W-1:0]     w_ad_word;
    logic                  w_fifo_valid;
    logic [DATA_W-1:0]     w_head_data;
    logic                  w_head_last;
    logic [SKID_CNT_W-1:0] w_fifo_cnt;

    assign w_pop = w_fifo_valid & m.ready;

    // Slots already spoken for after this cycle's pop: a new read is only
    // issued when its data is guaranteed a free FIFO entry on arrival.
    assign w_credit = 3'(w_fifo_cnt) + 3'(inflight_q) - 3'(w_pop);
    assign w_issue  = (state_q == DRAIN) && (issued_q < c_FRAME_LEN)
                    && (w_credit < 3'(SKID_DEPTH));

    generate
        if (READ_LAT != 0) begin : g_pipe
            assign w_push = inflight_q;
        end else begin : g_bypass
            assign w_push = w_issue;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        issued_d   = issued_q;
        inflight_d = (READ_LAT != 0) && w_issue;
        s.ready    = 1'b0;
        ram_ce     = 1'b0;
        ram_wre    = 1'b0;
        w_ad_word  = '0;
        frame_done = 1'b0;
        unique case (state_q)
            FILL: begin
                s.ready = 1'b1;
                if (s.valid) begin
                    ram_ce    = 1'b1;
                    ram_wre   = 1'b1;
                    w_ad_word = wr_ptr_q;
                    if (wr_ptr_q == c_LAST_IDX) begin
                        wr_ptr_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (w_issue) begin
                    ram_ce    = 1'b1;
                    w_ad_word = issued_q[ADDR_W-1:0];
                    issued_d  = issued_q + c_CNT_W'(1);
                end
                if (w_push) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
                // All reads are done once the last word leaves, so the
                // counters can be cleared without racing an issue or push.
                if (w_pop && w_head_last) begin
                    frame_done = 1'b1;
                    state_d    = FILL;
                    issued_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
        end
    end

    sp_buf_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (ram_do),
        .i_push_last (rd_ptr_q == c_LAST_IDX),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last),
        .o_cnt       (w_fifo_cnt)
    );

    assign m.valid = w_fifo_valid;
    assign m.data  = w_head_data;
    assign m_last  = w_fifo_valid & w_head_last;

    // SP RESET would clear the array, so it is never used.
    assign ram_reset = 1'b0;
    assign ram_oce   = (READ_LAT != 0);
    assign ram_ad    = ad_fmt(14'(w_ad_word), ADDR_LSB);
    assign ram_di    = s.data;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_frame_buffer_ctrl
// Purpose  : Drives one READ_LAT=1 and one READ_LAT=0 controller from the
//            same stimulus, each with a behavioural SP RAM, and scores both
//            output streams against a queue of the words written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_frame_buffer_ctrl;
    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 32;
    localparam int ADDR_W    = 5;
    localparam int ADDR_LSB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] s_data  = '0;
    logic              s_valid = 1'b0;
    logic              m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sp_ram_frame_buffer_ctrl_if #(.DATA_W(DATA_W)) s_if1 ();
    sp_ram_frame_buffer_ctrl_if #(.DATA_W(DATA_W)) m_if1 ();
    sp_ram_frame_buffer_ctrl_if #(.DATA_W(DATA_W)) s_if0 ();
    sp_ram_frame_buffer_ctrl_if #(.DATA_W(DATA_W)) m_if0 ();
    assign s_if1.data = s_data;  assign s_if1.valid = s_valid;  assign m_if1.ready = m_ready;
    assign s_if0.data = s_data;  assign s_if0.valid = s_valid;  assign m_if0.ready = m_ready;

    logic m_last1, fd1, ce1, oce1, wre1, rr1;
    logic m_last0, fd0, ce0, oce0, wre0, rr0;
    logic [13:0]       ad1, ad0;
    logic [DATA_W-1:0] di1, di0, do1, do0;

    sp_ram_frame_buffer_ctrl #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB), .READ_LAT(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s(s_if1), .m(m_if1), .m_last(m_last1), .frame_done(fd1),
        .ram_ce(ce1), .ram_oce(oce1), .ram_wre(wre1), .ram_reset(rr1), .ram_ad(ad1),
        .ram_di(di1), .ram_do(do1)
    );

    sp_ram_frame_buffer_ctrl #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB), .READ_LAT(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s(s_if0), .m(m_if0), .m_last(m_last0), .frame_done(fd0),
        .ram_ce(ce0), .ram_oce(oce0), .ram_wre(wre0), .ram_reset(rr0), .ram_ad(ad0),
        .ram_di(di0), .ram_do(do0)
    );

    // Behavioural SP RAMs: READ_MODE=1 registers the read, READ_MODE=0 is same-cycle.
    logic [DATA_W-1:0] mem1 [2**ADDR_W];
    logic [DATA_W-1:0] mem0 [2**ADDR_W];
    always @(posedge clk) begin
        if (ce1) begin
            if (wre1)      mem1[ad1[ADDR_LSB +: ADDR_W]] <= di1;
            else if (oce1) do1 <= mem1[ad1[ADDR_LSB +: ADDR_W]];
        end
        if (ce0 && wre0) mem0[ad0[ADDR_LSB +: ADDR_W]] <= di0;
    end
    assign do0 = mem0[ad0[ADDR_LSB +: ADDR_W]];

    // Reference model: the output of each controller is exactly the sequence
    // of words accepted, last flag on the final one; a controller accepts
    // input only between the end of one drain and the 32nd write.
    typedef struct packed { logic [DATA_W-1:0] data; logic last; } exp_t;
    exp_t exp_q1[$];
    exp_t exp_q0[$];
    bit                fill_m  [2];
    int                lat_cnt [2];
    bit                seen_v  [2];
    bit                stall_p [2];
    logic [DATA_W-1:0] stall_d [2];
    logic              stall_l [2];
    int                pops    [2];
    int                hs_cnt    = 0;
    bit                full_rate = 1'b0;
    int                rdy_mode  = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q1.delete();
        exp_q0.delete();
        for (int k = 0; k < 2; k++) begin
            fill_m[k] = 1'b1; lat_cnt[k] = 0; seen_v[k] = 1'b0; stall_p[k] = 1'b0; pops[k] = 0;
        end
        hs_cnt = 0;
    endtask

    task automatic mon(input int id, input logic mv, input logic mr, input logic [DATA_W-1:0] md,
                       input logic ml, input logic fd, input logic sr, input logic wre,
                       input logic ce, input logic [13:0] ad);
        exp_t  e       = '0;
        bit    have    = 1'b0;
        bit    pop     = mv && mr;
        int    exp_lat = (id == 1) ? 2 : 1;
        string p       = (id == 1) ? "lat1" : "lat0";
        logic [13:0] exp_ad = 14'(hs_cnt) << ADDR_LSB;

        chk(sr == fill_m[id], {p, " s_ready"}, 64'(sr), 64'(fill_m[id]));
        chk(wre == (s_valid && fill_m[id]), {p, " ram_wre"}, 64'(wre), 64'(s_valid && fill_m[id]));
        if (wre) chk(ce && ad == exp_ad, {p, " write ram_ad"}, 64'(ad), 64'(exp_ad));
        if (stall_p[id])
            chk(mv && md == stall_d[id] && ml == stall_l[id], {p, " stall hold"},
                64'({mv, ml, md}), 64'({1'b1, stall_l[id], stall_d[id]}));
        if (!fill_m[id] && !seen_v[id]) begin
            if (mv) begin
                chk(lat_cnt[id] == exp_lat, {p, " first m_valid latency"}, 64'(lat_cnt[id]), 64'(exp_lat));
                seen_v[id] = 1'b1;
            end else begin
                lat_cnt[id]++;
            end
        end else if (!fill_m[id] && full_rate) begin
            chk(mv, {p, " full-rate m_valid"}, 64'(mv), 64'(1));
        end
        if (mv) begin
            have = (id == 1) ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
            if (!have) begin
                chk(1'b0, {p, " unexpected m_valid"}, 64'(md), 64'(0));
            end else begin
                e = (id == 1) ? exp_q1[0] : exp_q0[0];
                chk(md == e.data && ml == e.last, {p, " m_data/m_last"},
                    64'({ml, md}), 64'({e.last, e.data}));
                if (pop) begin
                    if (id == 1) void'(exp_q1.pop_front());
                    else         void'(exp_q0.pop_front());
                    pops[id]++;
                end
            end
        end
        chk(fd == (pop && have && e.last), {p, " frame_done"}, 64'(fd), 64'(pop && have && e.last));
        if (pop && have && e.last) begin
            fill_m[id] = 1'b1; seen_v[id] = 1'b0; lat_cnt[id] = 0;
        end
        stall_p[id] = mv && !mr;
        stall_d[id] = md;
        stall_l[id] = ml;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1, m_if1.valid, m_ready, m_if1.data, m_last1, fd1, s_if1.ready, wre1, ce1, ad1);
            mon(0, m_if0.valid, m_ready, m_if0.data, m_last0, fd0, s_if0.ready, wre0, ce0, ad0);
            chk(u_dut1.u_skid.cnt_q <= 2, "lat1 fifo occupancy", 64'(u_dut1.u_skid.cnt_q), 64'(2));
            chk(u_dut0.u_skid.cnt_q <= 2, "lat0 fifo occupancy", 64'(u_dut0.u_skid.cnt_q), 64'(2));
        end
    end

    // m_ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random.
    initial begin : p_mready
        int c = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 4 == 0) || (c % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            c++;
        end
    end

    task automatic reset_checks(input string tag);
        chk(!m_if1.valid && !m_if0.valid, {tag, " m_valid"}, 64'({m_if1.valid, m_if0.valid}), 64'(0));
        chk(!m_last1 && !m_last0, {tag, " m_last"}, 64'({m_last1, m_last0}), 64'(0));
        chk(!fd1 && !fd0, {tag, " frame_done"}, 64'({fd1, fd0}), 64'(0));
        chk(!wre1 && !wre0 && !ce1 && !ce0, {tag, " ram_wre/ram_ce"}, 64'({wre1, wre0, ce1, ce0}), 64'(0));
        chk(!rr1 && !rr0, {tag, " ram_reset"}, 64'({rr1, rr0}), 64'(0));
        chk(s_if1.ready && s_if0.ready, {tag, " s_ready"}, 64'({s_if1.ready, s_if0.ready}), 64'(3));
    endtask

    // mode 0: data = base + index; mode 1: random data. s_valid offered every gap-th cycle.
    task automatic send_frame(input int mode, input logic [DATA_W-1:0] base, input int gap);
        exp_t e;
        int   cyc   = 0;
        int   guard = 0;
        while (!(s_if1.ready && s_if0.ready) && guard < 2000) begin
            @(posedge clk); #1; guard++;
        end
        pops[0] = 0; pops[1] = 0; hs_cnt = 0; guard = 0;
        while (hs_cnt < FRAME_LEN) begin
            if (guard > 4000) begin
                chk(1'b0, "fill timeout", 64'(hs_cnt), 64'(FRAME_LEN));
                break;
            end
            s_valid = (cyc % gap == 0) && s_if1.ready && s_if0.ready;
            s_data  = (mode == 1) ? DATA_W'($urandom) : base + DATA_W'(hs_cnt);
            @(posedge clk);
            if (s_valid) begin
                e.data = s_data;
                e.last = (hs_cnt == FRAME_LEN - 1);
                exp_q1.push_back(e);
                exp_q0.push_back(e);
                if (e.last) begin fill_m[0] = 1'b0; fill_m[1] = 1'b0; end
                hs_cnt++;
            end
            #1; cyc++; guard++;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int guard = 0;
        while ((exp_q1.size() != 0 || exp_q0.size() != 0 || !fill_m[0] || !fill_m[1]) && guard < 4000) begin
            @(posedge clk); #1; guard++;
        end
        chk(exp_q1.size() == 0 && exp_q0.size() == 0, "frame fully drained",
            64'(exp_q1.size() + exp_q0.size()), 64'(0));
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : p_main
        int guard;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;

        rdy_mode = 0; full_rate = 1'b1;              // basic frame, full rate
        send_frame(0, 32'h100, 1); wait_drained();
        full_rate = 1'b0;

        rdy_mode = 1;                                 // backpressure 1,0,0,1
        send_frame(1, '0, 1); wait_drained();

        rdy_mode = 2;                                 // input every 3rd cycle
        send_frame(1, '0, 3); wait_drained();
        send_frame(1, '0, 2); wait_drained();

        rdy_mode = 0; full_rate = 1'b1;               // random data, full rate
        send_frame(1, '0, 1); wait_drained();
        full_rate = 1'b0;

        rdy_mode = 1;                                 // reset after 10 outputs
        send_frame(0, 32'h300, 1);
        guard = 0;
        while (pops[1] < 10 && guard < 2000) begin @(posedge clk); #1; guard++; end
        chk(pops[1] >= 10, "outputs before mid-drain reset", 64'(pops[1]), 64'(10));
        rst_n = 1'b0;
        #1;
        reset_checks("mid-drain reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_mode = 0; full_rate = 1'b1;               // clean frame after reset
        send_frame(0, 32'h200, 1); wait_drained();
        full_rate = 1'b0;

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
